// File: rtl/if_id_stage.sv
// IF/ID pipeline register for the RV32I core: holds one fetched instruction in the decode slot,
// feeds the control unit, detects load-use hazards and absorbs one fetch in a skid buffer.
module if_id_stage #(
    parameter int XLEN          = 32,
    parameter bit CHECK_ILLEGAL = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            imem_valid,
    input  logic [31:0]     imem_instr,
    input  logic [XLEN-1:0] imem_pc,
    output logic            imem_ready,
    input  logic            ex_is_load,
    input  logic            ex_we_reg,
    input  logic [4:0]      ex_rd,
    input  logic            flush,
    output logic [16:0]     operation,
    output logic [31:0]     instr_out,
    output logic [XLEN-1:0] pc_out,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic            nop,
    output logic            stall,
    output logic            illegal
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    function automatic logic f_is_legal(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LOAD, OP_JALR, OP_S, OP_B, OP_LUI, OP_AUIPC, OP_JAL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic f_uses_rs1(input logic [6:0] op);
        return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
    endfunction

    function automatic logic f_uses_rs2(input logic [6:0] op);
        return (op == OP_R) || (op == OP_S) || (op == OP_B);
    endfunction

    logic            r_id_valid;
    logic [31:0]     r_id_instr;
    logic [XLEN-1:0] r_id_pc;
    logic            r_skid_full;
    logic [31:0]     r_skid_instr;
    logic [XLEN-1:0] r_skid_pc;

    logic            w_accept;
    logic [6:0]      w_opcode;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic            w_stall;
    logic            w_illegal;

    assign w_accept = imem_valid && !r_skid_full;
    assign w_opcode = r_id_instr[6:0];
    assign w_rs1    = r_id_instr[19:15];
    assign w_rs2    = r_id_instr[24:20];

    // Hazard only against a real load that writes a non-zero register this slot actually reads.
    assign w_stall = r_id_valid && ex_is_load && ex_we_reg && (ex_rd != 5'd0) &&
                     ((f_uses_rs1(w_opcode) && (ex_rd == w_rs1)) ||
                      (f_uses_rs2(w_opcode) && (ex_rd == w_rs2)));

    assign w_illegal = CHECK_ILLEGAL && r_id_valid && !f_is_legal(w_opcode);

    // Decode slot / skid buffer, priority flush > stall > advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id_valid   <= 1'b0;
            r_id_instr   <= '0;
            r_id_pc      <= '0;
            r_skid_full  <= 1'b0;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
        end else if (flush) begin
            r_id_valid  <= 1'b0;
            r_skid_full <= 1'b0;
        end else if (w_stall) begin
            if (w_accept) begin
                r_skid_full  <= 1'b1;
                r_skid_instr <= imem_instr;
                r_skid_pc    <= imem_pc;
            end
        end else if (r_skid_full) begin
            r_id_valid  <= 1'b1;
            r_id_instr  <= r_skid_instr;
            r_id_pc     <= r_skid_pc;
            r_skid_full <= 1'b0;
        end else if (w_accept) begin
            r_id_valid <= 1'b1;
            r_id_instr <= imem_instr;
            r_id_pc    <= imem_pc;
        end else begin
            r_id_valid <= 1'b0;
        end
    end

    // Ready comes from registered state only, so stall never reaches imem combinationally.
    assign imem_ready = !r_skid_full;
    assign operation  = {r_id_instr[31:25], r_id_instr[14:12], r_id_instr[6:0]};
    assign instr_out  = r_id_instr;
    assign pc_out     = r_id_pc;
    assign rs1        = w_rs1;
    assign rs2        = w_rs2;
    assign rd         = r_id_instr[11:7];
    assign stall      = w_stall;
    assign illegal    = w_illegal;
    assign nop        = !r_id_valid || w_stall || w_illegal;

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed vectors plus a queue scoreboard that checks every issued slot.
module tb_if_id_stage;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_valid;
    logic [31:0] imem_instr;
    logic [31:0] imem_pc;
    logic        imem_ready;
    logic        ex_is_load;
    logic        ex_we_reg;
    logic [4:0]  ex_rd;
    logic        flush;
    logic [16:0] operation;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [4:0]  rs1, rs2, rd;
    logic        nop, stall, illegal;

    logic        u1_imem_ready;
    logic [16:0] u1_operation;
    logic [31:0] u1_instr_out;
    logic [31:0] u1_pc_out;
    logic [4:0]  u1_rs1, u1_rs2, u1_rd;
    logic        u1_nop, u1_stall, u1_illegal;

    int checks = 0;
    int errors = 0;
    int n_issued = 0;
    beat_t exp_q[$];

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_LUI  = 32'h123452B7;
    localparam logic [31:0] I_ADDI = 32'h00A00093;
    localparam logic [31:0] I_BAD  = 32'h0000007F;

    always #5 clk = ~clk;

    if_id_stage #(.XLEN(32), .CHECK_ILLEGAL(1'b1)) u0 (
        .clk(clk), .rst(rst), .imem_valid(imem_valid), .imem_instr(imem_instr),
        .imem_pc(imem_pc), .imem_ready(imem_ready), .ex_is_load(ex_is_load),
        .ex_we_reg(ex_we_reg), .ex_rd(ex_rd), .flush(flush), .operation(operation),
        .instr_out(instr_out), .pc_out(pc_out), .rs1(rs1), .rs2(rs2), .rd(rd),
        .nop(nop), .stall(stall), .illegal(illegal)
    );

    if_id_stage #(.XLEN(32), .CHECK_ILLEGAL(1'b0)) u1 (
        .clk(clk), .rst(rst), .imem_valid(imem_valid), .imem_instr(imem_instr),
        .imem_pc(imem_pc), .imem_ready(u1_imem_ready), .ex_is_load(ex_is_load),
        .ex_we_reg(ex_we_reg), .ex_rd(ex_rd), .flush(flush), .operation(u1_operation),
        .instr_out(u1_instr_out), .pc_out(u1_pc_out), .rs1(u1_rs1), .rs2(u1_rs2), .rd(u1_rd),
        .nop(u1_nop), .stall(u1_stall), .illegal(u1_illegal)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic f_legal(input logic [6:0] op);
        return op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011 ||
               op == 7'b1100111 || op == 7'b0100011 || op == 7'b1100011 ||
               op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111;
    endfunction

    function automatic logic f_hazard(input logic [31:0] i);
        logic [6:0] op;
        logic u_1, u_2;
        op  = i[6:0];
        u_1 = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
        u_2 = op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011;
        return ex_is_load && ex_we_reg && (ex_rd != 5'd0) &&
               ((u_1 && ex_rd == i[19:15]) || (u_2 && ex_rd == i[24:20]));
    endfunction

    // Reference model: accepted legal beats queue up; flush or reset discards everything pending.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (imem_valid && imem_ready && f_legal(imem_instr[6:0]))
                exp_q.push_back('{instr: imem_instr, pc: imem_pc});
            if (flush)
                exp_q.delete();
        end
    end

    // Monitor: the head of the queue is the decode slot; it issues when not hazarded.
    always @(negedge clk) begin : mon
        logic  e_nop, e_stall;
        beat_t b;
        if (!rst) begin
            e_nop   = 1'b1;
            e_stall = 1'b0;
            if (exp_q.size() > 0) begin
                e_stall = f_hazard(exp_q[0].instr);
                e_nop   = e_stall;
            end
            chk("mon_nop", nop, e_nop);
            chk("mon_stall", stall, e_stall);
            chk("mon_ready", imem_ready, exp_q.size() < 2);
            if (!e_nop) begin
                b = exp_q.pop_front();
                n_issued++;
                chk("mon_instr", instr_out, b.instr);
                chk("mon_pc", pc_out, b.pc);
                chk("mon_op", operation, {b.instr[31:25], b.instr[14:12], b.instr[6:0]});
                chk("mon_rs1", rs1, b.instr[19:15]);
                chk("mon_rs2", rs2, b.instr[24:20]);
                chk("mon_rd", rd, b.instr[11:7]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] p);
        imem_valid = 1'b1;
        imem_instr = i;
        imem_pc    = p;
    endtask

    task automatic idle();
        imem_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [9];
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};
        return {7'($urandom), 5'($urandom_range(3)), 5'($urandom_range(3)), 3'($urandom),
                5'($urandom_range(3)), ops[$urandom_range(8)]};
    endfunction

    initial begin
        logic        rdy_prev;
        logic [31:0] pc_n;
        rst = 1'b1; imem_valid = 1'b0; imem_instr = '0; imem_pc = '0;
        ex_is_load = 1'b0; ex_we_reg = 1'b0; ex_rd = '0; flush = 1'b0;
        repeat (2) tick();
        chk("rst_nop", nop, 1); chk("rst_ready", imem_ready, 1);
        chk("rst_op", operation, 0); chk("rst_stall", stall, 0); chk("rst_illegal", illegal, 0);
        rst = 1'b0;

        drive(I_ADD, 32'h100); tick();
        drive(I_SUB, 32'h104); #1;
        chk("add_op", operation, 17'h00033); chk("add_rs1", rs1, 1); chk("add_rs2", rs2, 2);
        chk("add_rd", rd, 3); chk("add_nop", nop, 0); chk("add_pc", pc_out, 32'h100);
        tick(); idle(); #1;
        chk("sub_op", operation, 17'h08033); chk("sub_pc", pc_out, 32'h104); chk("sub_nop", nop, 0);
        tick(); #1;
        chk("empty_nop", nop, 1);

        drive(I_ADD, 32'h200); tick();
        ex_is_load = 1'b1; ex_we_reg = 1'b1; ex_rd = 5'd2; drive(I_SUB, 32'h204); #1;
        chk("lu_stall", stall, 1); chk("lu_nop", nop, 1); chk("lu_ready", imem_ready, 1);
        tick(); idle(); ex_is_load = 1'b0; #1;
        chk("lu_skid_ready", imem_ready, 0); chk("lu_release_stall", stall, 0);
        chk("lu_add_nop", nop, 0); chk("lu_add_op", operation, 17'h00033); chk("lu_add_pc", pc_out, 32'h200);
        tick(); #1;
        chk("lu_sub_op", operation, 17'h08033); chk("lu_sub_pc", pc_out, 32'h204);
        chk("lu_sub_ready", imem_ready, 1); chk("lu_sub_nop", nop, 0);
        tick(); #1;
        chk("lu_done_nop", nop, 1);

        drive(I_ADD, 32'h210); tick(); idle();
        ex_is_load = 1'b1; ex_we_reg = 1'b1; ex_rd = 5'd0; #1;
        chk("x0_stall", stall, 0); chk("x0_nop", nop, 0);
        drive(I_LUI, 32'h220); tick(); idle(); ex_rd = 5'd8; #1;
        chk("lui_stall", stall, 0); chk("lui_nop", nop, 0); chk("lui_op", operation, 17'h026B7);
        chk("lui_rs1", rs1, 8); chk("lui_rd", rd, 5);
        tick(); ex_is_load = 1'b0; #1;
        chk("lui_done_nop", nop, 1);

        drive(I_ADD, 32'h300); tick();
        ex_is_load = 1'b1; ex_we_reg = 1'b1; ex_rd = 5'd1; drive(I_SUB, 32'h304); tick();
        drive(I_ADDI, 32'h308); flush = 1'b1; #1;
        chk("fl_ready", imem_ready, 0); chk("fl_stall", stall, 1);
        tick(); flush = 1'b0; idle(); ex_is_load = 1'b0; #1;
        chk("fl_nop", nop, 1); chk("fl_ready_after", imem_ready, 1); chk("fl_stall_after", stall, 0);
        repeat (2) begin tick(); #1; chk("fl_no_replay", nop, 1); end

        drive(I_ADD, 32'h310); tick();
        drive(I_SUB, 32'h314); flush = 1'b1; #1;
        chk("fl2_issue", nop, 0);
        tick(); flush = 1'b0; idle(); #1;
        chk("fl2_drop", nop, 1);
        tick(); #1;
        chk("fl2_drop2", nop, 1);

        drive(I_BAD, 32'h400); tick(); idle(); #1;
        chk("ill_flag", illegal, 1); chk("ill_nop", nop, 1);
        chk("ill_off_flag", u1_illegal, 0); chk("ill_off_nop", u1_nop, 0);
        tick(); #1;
        chk("ill_gone", illegal, 0);

        drive(I_ADD, 32'h500); tick();
        ex_is_load = 1'b1; ex_we_reg = 1'b1; ex_rd = 5'd2; drive(I_SUB, 32'h504); tick(); idle(); #1;
        chk("rst_mid_ready_pre", imem_ready, 0);
        rst = 1'b1; #1;
        chk("rst_mid_nop", nop, 1); chk("rst_mid_ready", imem_ready, 1);
        chk("rst_mid_op", operation, 0); chk("rst_mid_instr", instr_out, 0);
        chk("rst_mid_pc", pc_out, 0); chk("rst_mid_stall", stall, 0);
        tick(); tick(); rst = 1'b0; ex_is_load = 1'b0;
        repeat (3) begin tick(); #1; chk("rst_no_replay", nop, 1); end

        pc_n = 32'h1000;
        rdy_prev = 1'b0;
        for (int c = 0; c < 600; c++) begin
            tick();
            if (!(imem_valid && !rdy_prev)) begin
                if ($urandom_range(9) < 6) begin
                    drive(rand_instr(), pc_n);
                    pc_n = pc_n + 32'd4;
                end else begin
                    idle();
                end
            end
            flush      = ($urandom_range(19) == 0);
            ex_is_load = ($urandom_range(9) < 3);
            ex_we_reg  = ($urandom_range(9) < 8);
            ex_rd      = 5'($urandom_range(3));
            rdy_prev   = imem_ready;
        end
        tick(); idle(); flush = 1'b0; ex_is_load = 1'b0;
        repeat (4) tick();
        chk("drain_empty", exp_q.size(), 0);
        chk("issued_any", n_issued > 20, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
